bus_cycle_initiator: RTL
========================

// Module: bus_cycle_initiator
// PURPOSE
//  Bus master that turns a simple request/response interface into 8088-style bus cycles (T1-T2-T3-[TW]-T4).
//  Drives status/strobes ALE, IO_OR_M, DT_OR_R, DEN_N, RD_N, WR_N and honours READY wait states.
//  Grants HOLD/HLDA between cycles. Sits on the CPU side of the bus controller; used for DMA/test mastering.
// PARAMETERS
//  ADDR_WIDTH      20   address bus width
//  DATA_WIDTH      8    data bus width
//  TIMEOUT_CYCLES  255  max TW states before abort (only with BUS_CYCLE_TIMEOUT_EN)
// PORTS
//  clock              in   1   system clock; one clock, all logic on posedge
//  reset_n            in   1   reset; reset is synchronous and active-low
//  cpu_clock_posedge  in   1   1-clock enable, CPU clock rising edge (state advance)
//  cpu_clock_negedge  in   1   1-clock enable, CPU clock falling edge (ALE end)
//  req_valid/req_ready in/out 1  request handshake
//  req_write          in   1   1=write, 0=read
//  req_io             in   1   1=I/O, 0=memory
//  req_address        in   ADDR_WIDTH
//  req_data           in   DATA_WIDTH  write data
//  rsp_valid          out  1   1-clock pulse, cycle complete
//  rsp_data           out  DATA_WIDTH  read data (0 for writes)
//  rsp_timeout        out  1   valid with rsp_valid; cycle aborted
//  READY              in   1   1=no wait; sampled at cpu_clock_posedge in T3/TW
//  HOLD / HLDA        in/out 1  bus hold request / acknowledge
//  ADDRESS            out  ADDR_WIDTH  latched address, held T1..T4
//  DATA_OUT, DATA_OUT_EN  out DATA_WIDTH,1  write data, driven T2..T4 of writes
//  DATA_IN            in   DATA_WIDTH
//  ALE, IO_OR_M, DT_OR_R, DEN_N, RD_N, WR_N  out 1 each  bus status/strobes
// BEHAVIOUR
//  States: IDLE, PEND, T1, T2, T3, TW, T4, HOLDING. All changes below occur on a clock with
//   cpu_clock_posedge=1 unless stated.
//  Reset (reset_n=0 at a clock edge, any state): state=IDLE; ALE=0, IO_OR_M=1, DT_OR_R=1, DEN_N=1,
//   RD_N=1, WR_N=1, HLDA=0, DATA_OUT_EN=0, rsp_valid=0, rsp_timeout=0, ADDRESS=0, rsp_data=0.
//   Mid-cycle reset aborts without rsp_valid.
//  req_ready = (state==IDLE) & ~HOLD. Accept latches write/io/address/data -> PEND (any clock).
//  IDLE: HOLD=1 has priority over req_valid -> HOLDING, HLDA=1 at next cpu_clock_posedge.
//  HOLDING: all strobes inactive; HOLD=0 -> HLDA=0, IDLE.
//  PEND->T1: ALE=1, IO_OR_M=req_io, DT_OR_R=req_write, ADDRESS valid. ALE=0 on first negedge in T1.
//  T1->T2: RD_N=0 (read) or WR_N=0 + DATA_OUT_EN=1 (write); DEN_N=0.
//  T2->T3 unconditional. T3/TW: READY=1 -> T4, else TW (TW repeats while READY=0).
//  ->T4: RD_N=WR_N=DEN_N=1; read captures DATA_IN into rsp_data on this clock; rsp_valid=1 one clock.
//  T4->IDLE: DATA_OUT_EN=0, IO_OR_M=1, DT_OR_R=1. HOLD asserted during a cycle is granted only after T4.
//  Minimum latency accept->rsp_valid: 4 cpu_clock_posedge events (PEND,T1,T2,T3 each one period).
//  req_valid held across a busy cycle is accepted in IDLE; no back-to-back T4->T1 bypass.
// CONFIGURATION
//  BUS_CYCLE_TIMEOUT_EN defined: TW counter; after TIMEOUT_CYCLES consecutive TW states, force T4,
//   rsp_timeout=1, rsp_data=all-ones. Undefined: no counter, TW indefinitely, rsp_timeout tied 0.
// STRUCTURE
//  bus_cycle_pkg: state enum (bus_state_t), IDLE-level constants for the status outputs.
//  Sub-module bus_wait_counter (TW count/terminal flag), instantiated only under BUS_CYCLE_TIMEOUT_EN.
// TESTING
//  Mem read, req_io=0 addr=20'hF0000, READY=1, DATA_IN=8'h5A -> ALE in T1, RD_N low T2-T3, rsp_data=8'h5A
//   after 4 CPU clocks, IO_OR_M=0, DT_OR_R=0.
//  I/O write addr=16'h0060 data=8'hA5 -> IO_OR_M=1, DT_OR_R=1, WR_N low T2-T3, DATA_OUT=8'hA5 w/ DATA_OUT_EN.
//  READY=0 for 3 CPU clocks in T3 -> exactly 3 TW states, RD_N stays low, rsp_valid one clock after READY=1.
//  HOLD raised during T2 -> cycle completes, HLDA=1 after T4, req_ready=0 until HOLD drops.
//  reset_n=0 during TW -> all outputs at reset values next clock, no rsp_valid.
//  (BUS_CYCLE_TIMEOUT_EN, TIMEOUT_CYCLES=4) READY stuck 0 -> T4 after 4 TW, rsp_timeout=1, rsp_data=8'hFF.

Source files
------------

// File: rtl/bus_cycle_pkg.sv
// Shared types and idle-level constants for the 8088-style bus cycle initiator.
package bus_cycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PEND    = 3'd1,
    ST_T1      = 3'd2,
    ST_T2      = 3'd3,
    ST_T3      = 3'd4,
    ST_TW      = 3'd5,
    ST_T4      = 3'd6,
    ST_HOLDING = 3'd7
  } bus_state_t;

  // Levels the status/strobe outputs rest at whenever no cycle is in flight.
  localparam logic IDLE_ALE     = 1'b0;
  localparam logic IDLE_IO_OR_M = 1'b1;
  localparam logic IDLE_DT_OR_R = 1'b1;
  localparam logic IDLE_DEN_N   = 1'b1;
  localparam logic IDLE_RD_N    = 1'b1;
  localparam logic IDLE_WR_N    = 1'b1;

endpackage

// File: rtl/bus_wait_counter.sv
// Counts consecutive TW states and flags when the abort limit has been reached.
module bus_wait_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic advance,
  input  logic clear,
  output logic terminal
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // advance wins over clear so the T3->TW step loads a count of one.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (advance) begin
      count <= count + CW'(1);
    end else if (clear) begin
      count <= '0;
    end
  end

  assign terminal = (count == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/bus_cycle_initiator.sv
// Request/response to 8088-style bus cycle master (T1-T2-T3-[TW]-T4) with HOLD/HLDA.
// Optional TW abort counter enabled by defining BUS_CYCLE_TIMEOUT_EN.
module bus_cycle_initiator
  import bus_cycle_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_clock_posedge,
  input  logic                  cpu_clock_negedge,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_io,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  input  logic                  READY,
  input  logic                  HOLD,
  output logic                  HLDA,
  output logic [ADDR_WIDTH-1:0] ADDRESS,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_OUT_EN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic                  ALE,
  output logic                  IO_OR_M,
  output logic                  DT_OR_R,
  output logic                  DEN_N,
  output logic                  RD_N,
  output logic                  WR_N,
  output bus_state_t            dbg_state
);

  // Request handshake: a transfer happens on a clock where req_valid and
  // req_ready are both high; req_ready only depends on state and HOLD.
  bus_state_t state, state_nxt;

  logic                  req_write_q, req_io_q;
  logic [ADDR_WIDTH-1:0] req_address_q;
  logic [DATA_WIDTH-1:0] req_data_q;

  logic                  ale_nxt, io_or_m_nxt, dt_or_r_nxt, den_n_nxt, rd_n_nxt, wr_n_nxt;
  logic                  hlda_nxt, data_out_en_nxt, rsp_valid_nxt, rsp_timeout_nxt;
  logic [ADDR_WIDTH-1:0] address_nxt;
  logic [DATA_WIDTH-1:0] data_out_nxt, rsp_data_nxt;
  logic                  accept;
  logic                  wait_terminal;

  assign req_ready = (state == ST_IDLE) && !HOLD;
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

`ifdef BUS_CYCLE_TIMEOUT_EN
  logic wait_advance;
  assign wait_advance = cpu_clock_posedge && (state_nxt == ST_TW);

  bus_wait_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .advance (wait_advance),
    .clear   (state != ST_TW),
    .terminal(wait_terminal)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wait_terminal      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      ALE           <= IDLE_ALE;
      IO_OR_M       <= IDLE_IO_OR_M;
      DT_OR_R       <= IDLE_DT_OR_R;
      DEN_N         <= IDLE_DEN_N;
      RD_N          <= IDLE_RD_N;
      WR_N          <= IDLE_WR_N;
      HLDA          <= 1'b0;
      DATA_OUT_EN   <= 1'b0;
      DATA_OUT      <= '0;
      ADDRESS       <= '0;
      rsp_valid     <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_data      <= '0;
      req_write_q   <= 1'b0;
      req_io_q      <= 1'b0;
      req_address_q <= '0;
      req_data_q    <= '0;
    end else begin
      state       <= state_nxt;
      ALE         <= ale_nxt;
      IO_OR_M     <= io_or_m_nxt;
      DT_OR_R     <= dt_or_r_nxt;
      DEN_N       <= den_n_nxt;
      RD_N        <= rd_n_nxt;
      WR_N        <= wr_n_nxt;
      HLDA        <= hlda_nxt;
      DATA_OUT_EN <= data_out_en_nxt;
      DATA_OUT    <= data_out_nxt;
      ADDRESS     <= address_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      rsp_data    <= rsp_data_nxt;
      if (accept) begin
        req_write_q   <= req_write;
        req_io_q      <= req_io;
        req_address_q <= req_address;
        req_data_q    <= req_data;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    ale_nxt         = ALE;
    io_or_m_nxt     = IO_OR_M;
    dt_or_r_nxt     = DT_OR_R;
    den_n_nxt       = DEN_N;
    rd_n_nxt        = RD_N;
    wr_n_nxt        = WR_N;
    hlda_nxt        = HLDA;
    data_out_en_nxt = DATA_OUT_EN;
    data_out_nxt    = DATA_OUT;
    address_nxt     = ADDRESS;
    rsp_valid_nxt   = 1'b0;
    rsp_timeout_nxt = 1'b0;
    rsp_data_nxt    = rsp_data;

    case (state)
      ST_IDLE: begin
        if (HOLD) begin
          if (cpu_clock_posedge) begin
            state_nxt = ST_HOLDING;
            hlda_nxt  = 1'b1;
          end
        end else if (req_valid) begin
          state_nxt = ST_PEND;
        end
      end
      ST_HOLDING: begin
        if (cpu_clock_posedge && !HOLD) begin
          state_nxt = ST_IDLE;
          hlda_nxt  = 1'b0;
        end
      end
      ST_PEND: begin
        if (cpu_clock_posedge) begin
          state_nxt   = ST_T1;
          ale_nxt     = 1'b1;
          io_or_m_nxt = req_io_q;
          dt_or_r_nxt = req_write_q;
          address_nxt = req_address_q;
        end
      end
      ST_T1: begin
        // ALE also drops on leaving T1 in case no falling edge was seen.
        if (cpu_clock_posedge) begin
          state_nxt = ST_T2;
          ale_nxt   = 1'b0;
          den_n_nxt = 1'b0;
          if (req_write_q) begin
            wr_n_nxt        = 1'b0;
            data_out_en_nxt = 1'b1;
            data_out_nxt    = req_data_q;
          end else begin
            rd_n_nxt = 1'b0;
          end
        end else if (cpu_clock_negedge) begin
          ale_nxt = 1'b0;
        end
      end
      ST_T2: begin
        if (cpu_clock_posedge) begin
          state_nxt = ST_T3;
        end
      end
      ST_T3, ST_TW: begin
        if (cpu_clock_posedge) begin
          if (READY || (state == ST_TW && wait_terminal)) begin
            state_nxt     = ST_T4;
            rd_n_nxt      = 1'b1;
            wr_n_nxt      = 1'b1;
            den_n_nxt     = 1'b1;
            rsp_valid_nxt = 1'b1;
            if (!READY) begin
              rsp_timeout_nxt = 1'b1;
              rsp_data_nxt    = '1;
            end else if (req_write_q) begin
              rsp_data_nxt = '0;
            end else begin
              rsp_data_nxt = DATA_IN;
            end
          end else begin
            state_nxt = ST_TW;
          end
        end
      end
      ST_T4: begin
        if (cpu_clock_posedge) begin
          state_nxt       = ST_IDLE;
          data_out_en_nxt = 1'b0;
          io_or_m_nxt     = IDLE_IO_OR_M;
          dt_or_r_nxt     = IDLE_DT_OR_R;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
